// File: rtl/i2c_pkg.sv
// Shared I2C arbiter types and constants: FSM state encoding, LED slave address, R/W codes.
package i2c_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam logic [6:0] LED_SLAVE_ADDR = 7'h55;
    localparam logic       I2C_RD         = 1'b1;
    localparam logic       I2C_WR         = 1'b0;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        valid_c  = 1'b0;
        idx_c    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr_i) + i;
            if (cand >= N) cand = cand - N;
            cand_idx = IDX_W'(cand);
            if (!valid_c && req_i[cand_idx]) begin
                valid_c = 1'b1;
                idx_c   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C byte-master between NUM_REQ requesters.
// Optional watchdog/abort path is built only when I2C_ARB_TIMEOUT_EN is defined.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_REQ),
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*7-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_nack,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_timeout,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    output logic                 m_abort,
    input  logic                 m_busy,
    input  logic                 m_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_rdata,
    output logic [IDX_W-1:0]     grant_idx,
    output logic [1:0]           arb_state
);

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_ISSUE = ARB_ISSUE;
    localparam logic [1:0] S_WAIT  = ARB_WAIT;
    localparam logic [1:0] S_RESP  = ARB_RESP;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("i2c_master_arbiter: unsupported NUM_REQ/TIMEOUT_CYC");
    end

    logic [6:0] addr_arr  [NUM_REQ];
    logic [7:0] wdata_arr [NUM_REQ];
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign addr_arr[gi]  = req_addr[7*gi +: 7];
        assign wdata_arr[gi] = req_wdata[8*gi +: 8];
    end

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [6:0]         m_addr_q, m_addr_d;
    logic               m_rw_q, m_rw_d;
    logic [7:0]         m_wdata_q, m_wdata_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               m_start_q, m_start_d;
    logic               rsp_nack_q, rsp_nack_d;
    logic [7:0]         rsp_rdata_q, rsp_rdata_d;
    logic               pick_valid_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               done_hit_c;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .valid_c (pick_valid_c),
        .idx_c   (pick_idx_c)
    );

    // m_done coinciding with the m_start strobe belongs to no command of ours
    assign done_hit_c = (state_q == S_WAIT) && m_done && !m_start_q;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_abort_q, m_abort_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        m_addr_d    = m_addr_q;
        m_rw_d      = m_rw_q;
        m_wdata_d   = m_wdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        m_start_d   = 1'b0;
        rsp_nack_d  = rsp_nack_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid_c) begin
                    grant_idx_d             = pick_idx_c;
                    m_addr_d                = addr_arr[pick_idx_c];
                    m_rw_d                  = req_rw[pick_idx_c];
                    m_wdata_d               = wdata_arr[pick_idx_c];
                    req_ready_d[pick_idx_c] = 1'b1;
                    state_d                 = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!m_busy) begin
                    m_start_d = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_hit_c) begin
                    rsp_nack_d               = m_nack;
                    rsp_rdata_d              = (m_rw_q == I2C_RD) ? m_rdata : 8'h00;
                    rsp_valid_d[grant_idx_q] = 1'b1;
                    state_d                  = S_RESP;
                end
            end
            S_RESP: begin
                rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                : IDX_W'(grant_idx_q + 1'b1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef I2C_ARB_TIMEOUT_EN
        // Watchdog: counts ISSUE+WAIT cycles, zero elsewhere so it restarts at every grant
        m_abort_d     = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = (state_q == S_ISSUE || state_q == S_WAIT) ? CNT_W'(cnt_q + 1'b1) : '0;
        if (done_hit_c) rsp_timeout_d = 1'b0;
        if ((state_q == S_ISSUE || state_q == S_WAIT) && !done_hit_c &&
            cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            m_abort_d                = 1'b1;
            m_start_d                = 1'b0;
            rsp_nack_d               = 1'b1;
            rsp_timeout_d            = 1'b1;
            rsp_rdata_d              = 8'h00;
            rsp_valid_d              = '0;
            rsp_valid_d[grant_idx_q] = 1'b1;
            state_d                  = S_RESP;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            m_addr_q    <= '0;
            m_rw_q      <= 1'b0;
            m_wdata_q   <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            m_start_q   <= 1'b0;
            rsp_nack_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            m_addr_q    <= m_addr_d;
            m_rw_q      <= m_rw_d;
            m_wdata_q   <= m_wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            m_start_q   <= m_start_d;
            rsp_nack_q  <= rsp_nack_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            m_abort_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            m_abort_q     <= m_abort_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign m_abort     = m_abort_q;
    assign rsp_timeout = rsp_timeout_q;
`else
    assign m_abort     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_nack  = rsp_nack_q;
    assign rsp_rdata = rsp_rdata_q;
    assign m_start   = m_start_q;
    assign m_addr    = m_addr_q;
    assign m_rw      = m_rw_q;
    assign m_wdata   = m_wdata_q;
    assign grant_idx = grant_idx_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; the watchdog scenario runs when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_master_arbiter;
    import i2c_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*7-1:0] req_addr;
    logic [NUM_REQ-1:0]   req_rw;
    logic [NUM_REQ*8-1:0] req_wdata;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic                 rsp_nack;
    logic [7:0]           rsp_rdata;
    logic                 rsp_timeout;
    logic                 m_start;
    logic [6:0]           m_addr;
    logic                 m_rw;
    logic [7:0]           m_wdata;
    logic                 m_abort;
    logic                 m_busy;
    logic                 m_done;
    logic                 m_nack;
    logic [7:0]           m_rdata;
    logic [IDX_W-1:0]     grant_idx;
    logic [1:0]           arb_state;

    int checks = 0;
    int errors = 0;

    i2c_master_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
        .m_abort(m_abort), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
        .m_rdata(m_rdata), .grant_idx(grant_idx), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "bench watchdog expired");
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_rw    = '0;
        req_wdata = '0;
        m_busy    = 1'b0;
        m_done    = 1'b0;
        m_nack    = 1'b0;
        m_rdata   = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_req(input int r, input logic [6:0] a, input logic rw, input logic [7:0] wd);
        req_addr[7*r +: 7]  = a;
        req_rw[r]           = rw;
        req_wdata[8*r +: 8] = wd;
    endtask

    // Master stand-in: waits for a grant and m_start, answers with done; returns what the response carried.
    task automatic serve(input logic nack, input logic [7:0] rd, output int g,
                         output logic [3:0] rv, output logic rn, output logic [7:0] rdat);
        g = -1; rv = '0; rn = 1'b0; rdat = 8'h00;
        for (int i = 0; i < 20 && req_ready == '0; i++) @(negedge clk);
        if (req_ready == '0) return;
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
        for (int i = 0; i < 20 && !m_start; i++) @(negedge clk);
        if (!m_start) begin g = -1; return; end
        m_busy = 1'b1;
        @(negedge clk);
        m_done = 1'b1; m_nack = nack; m_rdata = rd;
        @(negedge clk);
        m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00; m_busy = 1'b0;
        rv = rsp_valid; rn = rsp_nack; rdat = rsp_rdata;
    endtask

    task automatic test_reset();
        logic [49:0] all_out;
        apply_reset();
        all_out = {req_ready, rsp_valid, m_start, m_abort, m_addr, m_rw, m_wdata,
                   rsp_nack, rsp_rdata, rsp_timeout, grant_idx, arb_state};
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_single();
        set_req(0, LED_SLAVE_ADDR, I2C_WR, 8'hA5);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || m_start !== 1'b0) begin
            errors++; $display("FAIL single_accept: ready=%b start=%b expected 0001/0", req_ready, m_start);
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (m_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", m_start); end
        checks++;
        if (m_addr !== 7'h55 || m_wdata !== 8'hA5 || m_rw !== I2C_WR) begin
            errors++; $display("FAIL single_fields: addr=%h wdata=%h rw=%b expected 55/a5/0", m_addr, m_wdata, m_rw);
        end
        m_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (m_start !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL single_pulse_width: start=%b ready=%b expected 0/0000", m_start, req_ready);
        end
        m_done = 1'b1; m_nack = 1'b0;
        @(negedge clk);
        m_done = 1'b0; m_busy = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_nack !== 1'b0 || rsp_rdata !== 8'h00 || arb_state !== 2'd3) begin
            errors++; $display("FAIL single_resp: valid=%b nack=%b rdata=%h state=%0d expected 0001/0/00/3",
                               rsp_valid, rsp_nack, rsp_rdata, arb_state);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || arb_state !== 2'd0) begin
            errors++; $display("FAIL single_resp_end: valid=%b state=%0d expected 0000/0", rsp_valid, arb_state);
        end
    endtask

    task automatic test_round_robin();
        int         exp_order [5] = '{0, 1, 2, 3, 0};
        int         g;
        logic [3:0] rv;
        logic       rn;
        logic [7:0] rd;
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 7'(7'h20 + i), I2C_WR, 8'(8'h10 + i));
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            serve(1'b0, 8'h00, g, rv, rn, rd);
            checks++;
            if (g !== exp_order[n]) begin
                errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", n, g, exp_order[n]);
            end
            checks++;
            if (rv !== 4'(1 << exp_order[n])) begin
                errors++; $display("FAIL rr_rsp[%0d]: got %b expected %b", n, rv, 4'(1 << exp_order[n]));
            end
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_write();
        int         g;
        logic [3:0] rv;
        logic       rn;
        logic [7:0] rd;
        set_req(2, 7'h56, I2C_RD, 8'h00);
        req_valid = 4'b0100;
        serve(1'b0, 8'h3C, g, rv, rn, rd);
        req_valid = '0;
        checks++;
        if (g !== 2 || rv !== 4'b0100) begin
            errors++; $display("FAIL read_grant: g=%0d rsp=%b expected 2/0100", g, rv);
        end
        checks++;
        if (rd !== 8'h3C || rn !== 1'b0) begin
            errors++; $display("FAIL read_data: rdata=%h nack=%b expected 3c/0", rd, rn);
        end
        set_req(2, LED_SLAVE_ADDR, I2C_WR, 8'h5A);
        req_valid = 4'b0100;
        serve(1'b0, 8'hEE, g, rv, rn, rd);
        req_valid = '0;
        checks++;
        if (rv !== 4'b0100 || rd !== 8'h00) begin
            errors++; $display("FAIL write_rdata_zero: rsp=%b rdata=%h expected 0100/00", rv, rd);
        end
        checks++;
        if (m_addr !== 7'h55 || m_wdata !== 8'h5A) begin
            errors++; $display("FAIL write_fields: addr=%h wdata=%h expected 55/5a", m_addr, m_wdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nack();
        int         g;
        logic [3:0] rv;
        logic       rn;
        logic [7:0] rd;
        set_req(3, 7'h12, I2C_WR, 8'h01);
        set_req(1, LED_SLAVE_ADDR, I2C_WR, 8'h02);
        req_valid = 4'b1010;
        serve(1'b1, 8'h00, g, rv, rn, rd);
        req_valid = 4'b0010;
        checks++;
        if (g !== 3 || rv !== 4'b1000 || rn !== 1'b1) begin
            errors++; $display("FAIL nack_resp: g=%0d rsp=%b nack=%b expected 3/1000/1", g, rv, rn);
        end
        serve(1'b0, 8'h00, g, rv, rn, rd);
        req_valid = '0;
        checks++;
        if (g !== 1 || rv !== 4'b0010 || rn !== 1'b0) begin
            errors++; $display("FAIL nack_next: g=%0d rsp=%b nack=%b expected 1/0010/0", g, rv, rn);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy();
        int early;
        set_req(0, 7'h33, I2C_WR, 8'hC3);
        req_valid = 4'b0001;
        m_busy    = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL busy_accept: got %b expected 0001", req_ready); end
        req_valid = '0;
        early = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_start !== 1'b0) early++;
        end
        checks++;
        if (early !== 0 || arb_state !== 2'd1) begin
            errors++; $display("FAIL busy_hold: early_starts=%0d state=%0d expected 0/1", early, arb_state);
        end
        m_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (m_start !== 1'b1) begin errors++; $display("FAIL busy_start: got %b expected 1", m_start); end
        m_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (m_start !== 1'b0) begin errors++; $display("FAIL busy_single_pulse: got %b expected 0", m_start); end
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_busy = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL busy_resp: got %b expected 0001", rsp_valid); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        logic [49:0] all_out;
        int          stray;
        set_req(1, LED_SLAVE_ADDR, I2C_WR, 8'h77);
        req_valid = 4'b0010;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        m_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (arb_state !== 2'd2) begin errors++; $display("FAIL rst_wait_state: got %0d expected 2", arb_state); end
        #2 rst_n = 1'b0;
        #1;
        all_out = {req_ready, rsp_valid, m_start, m_abort, m_addr, m_rw, m_wdata,
                   rsp_nack, rsp_rdata, rsp_timeout, grant_idx, arb_state};
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL rst_async_clear: got %h expected 0", all_out); end
        m_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== '0 || m_abort !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin errors++; $display("FAIL rst_no_resp: stray=%0d expected 0", stray); end
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        apply_reset();
        set_req(0, 7'h12, I2C_WR, 8'h99);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (m_start) m_busy = 1'b1;
            if (m_abort) break;
        end
        checks++;
        if (n !== 50) begin errors++; $display("FAIL timeout_cycle: abort after %0d expected 50", n); end
        checks++;
        if (rsp_timeout !== 1'b1 || rsp_nack !== 1'b1 || rsp_valid !== 4'b0001 || rsp_rdata !== 8'h00) begin
            errors++; $display("FAIL timeout_resp: to=%b nack=%b valid=%b rdata=%h expected 1/1/0001/00",
                               rsp_timeout, rsp_nack, rsp_valid, rsp_rdata);
        end
        m_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (m_abort !== 1'b0) begin errors++; $display("FAIL timeout_pulse: abort=%b expected 0", m_abort); end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_read_write();
        test_nack();
        test_busy();
        test_reset_in_wait();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
